fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents the fetched PC/instruction pair (plus a valid flag) to the IF/ID pipeline register. It accepts a redirect from the branch/jump resolution logic and a stall from hazard control. It sits directly upstream of IF_ID.

---
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues requests to
// instruction memory over a req/ack handshake and presents the fetched
// PC/instruction pair (plus a valid flag) to the IF/ID pipeline register.
// A redirect from branch/jump resolution takes priority over a stall from
// hazard control.
//
// Parameters
//   PC_WIDTH    program counter width
//   INST_WIDTH  instruction width
//   RESET_PC    PC value loaded by reset
//
// Ports
//   clk              clock, all state updates on rising edge
//   rst              asynchronous active-high reset
//   stall            hold fetch outputs and PC
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC when redirect_valid=1
//   imem_req         instruction memory request
//   imem_addr        request address, stable until acknowledged
//   imem_ack         memory returns imem_data this cycle
//   imem_data        instruction word, sampled only when imem_ack=1
//   PC_out           PC of inst_out
//   inst_out         fetched instruction, 0 (NOP) when invalid
//   valid_out        PC_out/inst_out hold a real instruction
//
// Optional feature (macro FETCH_CNT_EN)
//   fetch_count      number of valid_out=1 updates
//   bubble_count     number of cycles valid_out loads 0 in REQ/KILL

module fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 22,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]   PC_out,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  valid_out
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

  state_t                state, state_n;
  logic [PC_WIDTH-1:0]   pc, pc_n;
  logic [PC_WIDTH-1:0]   req_addr, req_addr_n;
  logic [INST_WIDTH-1:0] hold_inst, hold_inst_n;
  logic [PC_WIDTH-1:0]   hold_pc, hold_pc_n;
  logic [PC_WIDTH-1:0]   pc_out_n;
  logic [INST_WIDTH-1:0] inst_out_n;
  logic                  valid_out_n;

  // A request is outstanding in REQ and in KILL (where the stale request
  // must still complete before the new path can be fetched).
  assign imem_req  = (state == REQ) || (state == KILL);
  assign imem_addr = req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_inst <= '0;
      hold_pc   <= '0;
      PC_out    <= '0;
      inst_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
      PC_out    <= pc_out_n;
      inst_out  <= inst_out_n;
      valid_out <= valid_out_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    pc_out_n    = PC_out;
    inst_out_n  = inst_out;
    valid_out_n = valid_out;

    case (state)
      IDLE: begin
        state_n    = REQ;
        req_addr_n = pc;
      end

      REQ: begin
        if (redirect_valid) begin
          // Wrong-path word is dropped; without an ack the request cannot be
          // withdrawn, so KILL waits for the stale response.
          pc_n        = redirect_target;
          valid_out_n = 1'b0;
          inst_out_n  = '0;
          if (imem_ack) begin
            req_addr_n = redirect_target;
          end else begin
            state_n = KILL;
          end
        end else if (imem_ack) begin
          if (stall) begin
            // Park the returned word until the stall lifts.
            hold_inst_n = imem_data;
            hold_pc_n   = req_addr;
            state_n     = HOLD;
          end else begin
            pc_out_n    = req_addr;
            inst_out_n  = imem_data;
            valid_out_n = 1'b1;
            pc_n        = req_addr + PC_WIDTH'(1);
            req_addr_n  = req_addr + PC_WIDTH'(1);
          end
        end else if (!stall) begin
          valid_out_n = 1'b0;
          inst_out_n  = '0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_n        = redirect_target;
          req_addr_n  = redirect_target;
          valid_out_n = 1'b0;
          inst_out_n  = '0;
          state_n     = REQ;
        end else if (!stall) begin
          pc_out_n    = hold_pc;
          inst_out_n  = hold_inst;
          valid_out_n = 1'b1;
          pc_n        = hold_pc + PC_WIDTH'(1);
          req_addr_n  = hold_pc + PC_WIDTH'(1);
          state_n     = REQ;
        end
      end

      KILL: begin
        valid_out_n = 1'b0;
        inst_out_n  = '0;
        if (redirect_valid) begin
          pc_n = redirect_target;
        end
        if (imem_ack) begin
          // A redirect arriving with the stale ack wins over the stored pc.
          req_addr_n = redirect_valid ? redirect_target : pc;
          state_n    = REQ;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef FETCH_CNT_EN
  logic fetch_inc;
  logic bubble_inc;

  assign fetch_inc  = ((state == REQ)  && !redirect_valid && imem_ack && !stall) ||
                      ((state == HOLD) && !redirect_valid && !stall);
  assign bubble_inc = ((state == REQ) && (redirect_valid || (!imem_ack && !stall))) ||
                      (state == KILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_inc)  fetch_count  <= fetch_count + 32'd1;
      if (bubble_inc) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//
// Directed bench for fetch_unit (RESET_PC = 0x10). Instruction memory is
// modelled as imem_data = imem_addr[21:0] ^ 22'h155555; expected words are
// written out as hand-computed constants. Inputs change and outputs are
// sampled at the falling clock edge.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [21:0] imem_data;
  logic [31:0] PC_out;
  logic [21:0] inst_out;
  logic        valid_out;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr[21:0] ^ 22'h155555;

  fetch_unit #(
    .PC_WIDTH   (32),
    .INST_WIDTH (22),
    .RESET_PC   (32'h10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .PC_out          (PC_out),
    .inst_out        (inst_out),
    .valid_out       (valid_out)
`ifdef FETCH_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .bubble_count    (bubble_count)
`endif
  );

  // Drive the DUT inputs for the coming cycle
  task automatic applyStimulus(input logic ack, input logic stl,
                               input logic rv, input logic [31:0] tgt);
    imem_ack        = ack;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  // One comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every observable output of the fetch stage
  task automatic checkAll(input string step, input logic e_req,
                          input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic [21:0] e_inst, input logic e_valid);
    checkOutput({step, ".imem_req"},  32'(imem_req),  32'(e_req));
    checkOutput({step, ".imem_addr"}, imem_addr,      e_addr);
    checkOutput({step, ".PC_out"},    PC_out,         e_pc);
    checkOutput({step, ".inst_out"},  32'(inst_out),  32'(e_inst));
    checkOutput({step, ".valid_out"}, 32'(valid_out), 32'(e_valid));
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) nextCycle();
    checkAll("reset", 1'b0, 32'h10, 32'h0, 22'h0, 1'b0);
`ifdef FETCH_CNT_EN
    checkOutput("reset.fetch_count",  fetch_count,  32'd0);
    checkOutput("reset.bubble_count", bubble_count, 32'd0);
`endif

    // Zero-wait memory from RESET_PC
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("seq_idle", 1'b1, 32'h10, 32'h0,  22'h0,      1'b0);
    nextCycle(); checkAll("seq_10",   1'b1, 32'h11, 32'h10, 22'h155545, 1'b1);
    nextCycle(); checkAll("seq_11",   1'b1, 32'h12, 32'h11, 22'h155544, 1'b1);
    nextCycle(); checkAll("seq_12",   1'b1, 32'h13, 32'h12, 22'h155547, 1'b1);

    // Redirect with ack to 0x20, then ack delayed two cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20);
    nextCycle(); checkAll("dly_redir", 1'b1, 32'h20, 32'h12, 22'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("dly_bub1",  1'b1, 32'h20, 32'h12, 22'h0, 1'b0);
    nextCycle(); checkAll("dly_bub2",  1'b1, 32'h20, 32'h12, 22'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("dly_20",    1'b1, 32'h21, 32'h20, 22'h155575, 1'b1);

    // Redirect to 0x2F, fetch it, then ack 0x30 under a three-cycle stall
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h2F);
    nextCycle(); checkAll("stl_redir", 1'b1, 32'h2F, 32'h20, 22'h0,      1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("stl_2f",    1'b1, 32'h30, 32'h2F, 22'h15557A, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle(); checkAll("stl_hold1", 1'b0, 32'h30, 32'h2F, 22'h15557A, 1'b1);
    nextCycle(); checkAll("stl_hold2", 1'b0, 32'h30, 32'h2F, 22'h15557A, 1'b1);
    nextCycle(); checkAll("stl_hold3", 1'b0, 32'h30, 32'h2F, 22'h15557A, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("stl_30",    1'b1, 32'h31, 32'h30, 22'h155565, 1'b1);

    // Request at 0x40, redirect to 0x100 before its ack, stale ack 2 cycles later
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    nextCycle(); checkAll("kill_req40", 1'b1, 32'h40, 32'h30, 22'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    nextCycle(); checkAll("kill_wait1", 1'b1, 32'h40, 32'h30, 22'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("kill_wait2", 1'b1, 32'h40, 32'h30, 22'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("kill_drop",  1'b1, 32'h100, 32'h30, 22'h0, 1'b0);
    nextCycle(); checkAll("kill_100",   1'b1, 32'h101, 32'h100, 22'h155455, 1'b1);

    // Redirect together with stall while in HOLD, then PC wrap-around
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle(); checkAll("hold_park",  1'b0, 32'h101, 32'h100, 22'h155455, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    nextCycle(); checkAll("hold_redir", 1'b1, 32'hFFFF_FFFF, 32'h100, 22'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("wrap_ffff",  1'b1, 32'h0, 32'hFFFF_FFFF, 22'h2AAAAA, 1'b1);
    nextCycle(); checkAll("wrap_0",     1'b1, 32'h1, 32'h0, 22'h155555, 1'b1);

    // Enter KILL, then assert reset in the middle of the cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    nextCycle(); checkAll("rst_kill",   1'b1, 32'h1, 32'h0, 22'h0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkAll("rst_async", 1'b0, 32'h10, 32'h0, 22'h0, 1'b0);
`ifdef FETCH_CNT_EN
    checkOutput("rst_async.fetch_count",  fetch_count,  32'd0);
    checkOutput("rst_async.bubble_count", bubble_count, 32'd0);
`endif
    nextCycle(); checkAll("rst_held",   1'b0, 32'h10, 32'h0, 22'h0, 1'b0);
    rst = 1'b0;
    nextCycle(); checkAll("rst_lateack", 1'b1, 32'h10, 32'h0, 22'h0, 1'b0);
    nextCycle(); checkAll("rst_10",      1'b1, 32'h11, 32'h10, 22'h155545, 1'b1);
`ifdef FETCH_CNT_EN
    checkOutput("cnt1.fetch_count",  fetch_count,  32'd1);
    checkOutput("cnt1.bubble_count", bubble_count, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle(); checkAll("rst_bubble",  1'b1, 32'h11, 32'h10, 22'h0, 1'b0);
`ifdef FETCH_CNT_EN
    checkOutput("cnt2.fetch_count",  fetch_count,  32'd1);
    checkOutput("cnt2.bubble_count", bubble_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
